// File: rtl/comparador_serial_id.sv
// Bit-serial MSB-first unsigned magnitude comparator.
// Latches both operands on start and scans one bit per clock, so each comparison takes WIDTH cycles.
module comparador_serial_id #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("comparador_serial_id: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CntW-1:0]  cnt;
    logic             dec_lt;
    logic             dec_gt;

    logic bit_a;
    logic bit_b;
    logic decided;
    logic nxt_lt;
    logic nxt_gt;

    // Once either flag is set, the first differing bit has decided and later bits are ignored.
    always_comb begin
        bit_a   = sa[WIDTH-1];
        bit_b   = sb[WIDTH-1];
        decided = dec_lt | dec_gt;
        nxt_gt  = decided ? dec_gt : (bit_a & ~bit_b);
        nxt_lt  = decided ? dec_lt : (~bit_a & bit_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            dec_lt <= 1'b0;
            dec_gt <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        sa     <= a_in;
                        sb     <= b_in;
                        dec_lt <= 1'b0;
                        dec_gt <= 1'b0;
                        cnt    <= CntLast;
                        state  <= StCompare;
                    end else begin
                        state <= StIdle;
                    end
                end
                StCompare: begin
                    dec_lt <= nxt_lt;
                    dec_gt <= nxt_gt;
                    sa     <= {sa[WIDTH-2:0], 1'b0};
                    sb     <= {sb[WIDTH-2:0], 1'b0};
                    // Fixed latency: leave only after the LSB, even if the MSB already decided.
                    if (cnt == '0) begin
                        state <= StDone;
                        lt    <= nxt_lt;
                        gt    <= nxt_gt;
                        eq    <= ~(nxt_lt | nxt_gt);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state == StCompare);
    assign done = (state == StDone);

endmodule

// File: tb/tb_comparador_serial_id.sv
// Scoreboard bench for comparador_serial_id: stimulus queues expected {lt,eq,gt},
// a negedge monitor pops and checks on every done strobe.
module tb_comparador_serial_id;
    localparam int unsigned WIDTH = 8;
    localparam logic [2:0] ExpLt = 3'b100;
    localparam logic [2:0] ExpEq = 3'b010;
    localparam logic [2:0] ExpGt = 3'b001;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;

    typedef struct {
        logic [2:0] res;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         checks;
    int         errors;
    int         busy_run;
    logic [2:0] hold_exp;
    logic       finish_req;
    logic       finish_ack;

    comparador_serial_id #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: all comparisons happen here, half a cycle away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checks++;
            if ({busy, done, lt, eq, gt} != 5'b0) begin
                errors++;
                $display("FAIL reset_outputs got busy,done,lt,eq,gt=%b want=00000",
                         {busy, done, lt, eq, gt});
            end
            hold_exp = 3'b000;
            busy_run = 0;
        end else if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got done=1 lt,eq,gt=%b want no done", {lt, eq, gt});
            end else begin
                e = exp_q.pop_front();
                if ({lt, eq, gt} != e.res || busy || busy_run != int'(WIDTH)) begin
                    errors++;
                    $display("FAIL %s got lt,eq,gt=%b busy=%b busy_cycles=%0d want lt,eq,gt=%b busy=0 busy_cycles=%0d",
                             e.name, {lt, eq, gt}, busy, busy_run, e.res, WIDTH);
                end
                hold_exp = e.res;
            end
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            checks++;
            if ({lt, eq, gt} != hold_exp || busy_run > int'(WIDTH)) begin
                errors++;
                $display("FAIL result_hold got lt,eq,gt=%b busy_cycles=%0d want lt,eq,gt=%b busy_cycles<=%0d",
                         {lt, eq, gt}, busy_run, hold_exp, WIDTH);
            end
        end
        if (finish_req && !finish_ack) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_done got pending=%0d want pending=0", exp_q.size());
            end
            finish_ack = 1'b1;
        end
    end

    task automatic push_exp(input logic [2:0] res, input string nm);
        exp_t e;
        e.res  = res;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Called just after a posedge; the start pulse is accepted at the next edge.
    task automatic run_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] res, input string nm);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        push_exp(res, nm);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (WIDTH + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        busy_run   = 0;
        hold_exp   = 3'b000;
        finish_req = 1'b0;
        finish_ack = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        a_in       = '0;
        b_in       = '0;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one(8'hA5, 8'hA5, ExpEq, "equal_a5");
        run_one(8'h80, 8'h7F, ExpGt, "msb_decides_gt");
        run_one(8'h12, 8'h13, ExpLt, "lsb_decides_lt");
        run_one(8'hFF, 8'h00, ExpGt, "ff_vs_00");
        run_one(8'h00, 8'hFF, ExpLt, "00_vs_ff");
        run_one(8'h01, 8'h80, ExpLt, "01_vs_80");

        // start and operand changes during COMPARE must be ignored
        a_in  = 8'h40;
        b_in  = 8'h41;
        start = 1'b1;
        push_exp(ExpLt, "ignore_start_in_compare");
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h00;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (WIDTH + 12) @(posedge clk);
        #1;

        // Back-to-back with start held high
        a_in  = 8'h10;
        b_in  = 8'h20;
        start = 1'b1;
        push_exp(ExpLt, "b2b_first");
        @(posedge clk);
        #1;
        a_in = 8'h30;
        b_in = 8'h30;
        push_exp(ExpEq, "b2b_second");
        repeat (WIDTH + 1) @(posedge clk);
        #1 start = 1'b0;
        repeat (WIDTH + 2) @(posedge clk);
        #1;

        // Reset mid-operation: abandoned, so nothing is queued for it
        a_in  = 8'hF0;
        b_in  = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (WIDTH + 4) @(posedge clk);
        #1;
        run_one(8'h01, 8'h02, ExpLt, "after_reset_lt");

        finish_req = 1'b1;
        for (int i = 0; i < 10 && !finish_ack; i++) @(posedge clk);
        if (!finish_ack) begin
            $display("FAIL finish_handshake got ack=0 want ack=1");
            $fatal(1, "monitor did not respond");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
